// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module : ps2_pkg
//  Shared constants, FSM encoding and FIFO entry layout for the PS/2 receiver.
//  Rev    : 1.0
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    localparam int PS2_ENTRY_W = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module : ps2_sync_fifo
//  Generic synchronous first-word-fall-through FIFO; head is combinational.
//  Rev    : 1.0
// ============================================================================
module ps2_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_rd;
    logic w_wr;

    assign empty = (r_count == '0);
    assign full  = (r_count == C_FULL);
    assign w_rd  = rd_en & ~empty;
    // A full FIFO still accepts a write when a read frees the head slot.
    assign w_wr  = wr_en & (~full | w_rd);
    assign dout  = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module : ps2_scan_rx
//  PS/2 keyboard frame receiver with E0/F0 prefix folding and FWFT output FIFO.
//  Rev    : 1.0
// ============================================================================
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic       valid,
    output logic [7:0] code,
    output logic       brk,
    output logic       ext,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic [1:0]    r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_byte_done;
    logic          r_frame_err;
    logic [TW-1:0] r_to_cnt;
    logic          r_ext_pend;
    logic          r_brk_pend;
    logic          r_overflow;

    logic          w_fall;
    logic          w_bit;
    logic          w_is_pfx;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    ps2_entry_t    w_entry;
    ps2_entry_t    w_head;
    logic [PS2_ENTRY_W-1:0] w_dout;

    // Sync FFs reset high (bus idle level) so leaving reset never fakes a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit  = r_dat_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'd0;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_fall || (r_state == ST_IDLE)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if ((r_state != ST_IDLE) && !w_fall && (r_to_cnt == C_TO_LAST)) begin
                r_frame_err <= 1'b1;
                r_state     <= ST_IDLE;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_bit) begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        if (^{r_shift, w_bit}) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        if (w_bit) begin
                            r_byte_done <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // r_shift is only updated in DATA, so it still holds the byte here.
    assign w_is_pfx = (r_shift == PS2_PFX_EXT) || (r_shift == PS2_PFX_BRK);
    assign w_push   = r_byte_done & ~w_is_pfx;

    always_ff @(posedge clk) begin
        if (rst || r_frame_err) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (r_byte_done) begin
            if (r_shift == PS2_PFX_EXT) begin
                r_ext_pend <= 1'b1;
            end else if (r_shift == PS2_PFX_BRK) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !rd_en) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_entry.ext  = r_ext_pend;
    assign w_entry.brk  = r_brk_pend;
    assign w_entry.code = r_shift;

    ps2_sync_fifo #(
        .WIDTH (PS2_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (w_push),
        .din   (w_entry),
        .rd_en (rd_en),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    assign w_head    = ps2_entry_t'(w_dout);
    assign valid     = ~w_empty;
    assign code      = w_head.code;
    assign brk       = w_head.brk;
    assign ext       = w_head.ext;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module : tb_ps2_scan_rx
//  Self-checking bench: table-driven frames plus overflow/timeout/reset runs.
//  Rev    : 1.0
// ============================================================================
module tb_ps2_scan_rx;

    localparam int HALF = 20;
    localparam int TO   = 200;
    localparam int DEP  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       valid;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       frame_err;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_scan_rx #(
        .FIFO_DEPTH     (DEP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .valid     (valid),
        .code      (code),
        .brk       (brk),
        .ext       (ext),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         n;
        int         bad_idx;
        int         bad_kind;
        int         mode;
        bit         has_entry;
        logic [7:0] e_code;
        bit         e_brk;
        bit         e_ext;
        int         e_err;
    } vec_t;

    vec_t       vt [9];
    logic [9:0] sb [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         err_seen = 0;

    always @(posedge clk) begin
        if (!rst && frame_err) err_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // mode 1: check push latency on the stop edge; mode 2: pop the head in the push cycle.
    task automatic ps2_bit(input logic v, input int mode, input bit is_stop);
        @(negedge clk);
        ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (is_stop && mode == 1) begin
            repeat (3) @(negedge clk);
            chk("latency_n3_valid", {31'd0, valid}, 32'd0);
            @(negedge clk);
            chk("latency_n4_valid", {31'd0, valid}, 32'd1);
            repeat (HALF - 4) @(negedge clk);
        end else if (is_stop && mode == 2) begin
            repeat (3) @(negedge clk);
            if (sb.size() == 0) begin
                chk("rdpush_sb_nonempty", 32'd0, 32'd1);
            end else begin
                chk("rdpush_head", {22'd0, ext, brk, code}, {22'd0, sb[0]});
                void'(sb.pop_front());
            end
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (HALF - 4) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    // bad_kind: 0 good, 1 flipped parity, 2 stop bit low
    task automatic send_frame(input logic [7:0] d, input int bad_kind, input int mode);
        logic par;
        par = ~^d;
        if (bad_kind == 1) par = ~par;
        ps2_bit(1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 0, 1'b0);
        ps2_bit(par, 0, 1'b0);
        ps2_bit((bad_kind == 2) ? 1'b0 : 1'b1, mode, 1'b1);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic read_check(input string name);
        logic [9:0] exp;
        int         t;
        t = 0;
        while (!valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!valid) begin
            chk({name, "_valid_timeout"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            chk({name, "_unexpected_entry"}, {22'd0, ext, brk, code}, 32'd0);
        end else begin
            exp = sb.pop_front();
            chk({name, "_code"}, {24'd0, code}, {24'd0, exp[7:0]});
            chk({name, "_brk"},  {31'd0, brk},  {31'd0, exp[8]});
            chk({name, "_ext"},  {31'd0, ext},  {31'd0, exp[9]});
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_valid"},     {31'd0, valid},     32'd0);
        chk({name, "_code"},      {24'd0, code},      32'd0);
        chk({name, "_brk"},       {31'd0, brk},       32'd0);
        chk({name, "_ext"},       {31'd0, ext},       32'd0);
        chk({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({name, "_overflow"},  {31'd0, overflow},  32'd0);
    endtask

    function automatic logic [7:0] pick(input vec_t v, input int j);
        case (j)
            0:       return v.b0;
            1:       return v.b1;
            default: return v.b2;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int e0;

        //       b0     b1     b2     n  bad kind mode ent  code  brk ext err
        vt[0] = '{8'h1C, 8'h00, 8'h00, 1, -1, 0,  1,   1, 8'h1C, 0,  0,  0};
        vt[1] = '{8'hF0, 8'h1C, 8'h00, 2, -1, 0,  0,   1, 8'h1C, 1,  0,  0};
        vt[2] = '{8'hE0, 8'hF0, 8'h75, 3, -1, 0,  0,   1, 8'h75, 1,  1,  0};
        vt[3] = '{8'h1C, 8'h00, 8'h00, 1,  0, 1,  0,   0, 8'h00, 0,  0,  1};
        vt[4] = '{8'h32, 8'h00, 8'h00, 1, -1, 0,  0,   1, 8'h32, 0,  0,  0};
        vt[5] = '{8'hE0, 8'h6B, 8'h00, 2, -1, 0,  0,   1, 8'h6B, 0,  1,  0};
        vt[6] = '{8'hE0, 8'hF0, 8'h1C, 3,  1, 1,  0,   1, 8'h1C, 0,  0,  1};
        vt[7] = '{8'h5A, 8'h00, 8'h00, 1,  0, 2,  0,   0, 8'h00, 0,  0,  1};
        vt[8] = '{8'hE0, 8'h74, 8'h00, 2,  0, 2,  0,   1, 8'h74, 0,  0,  1};

        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            e0 = err_seen;
            for (int j = 0; j < vt[i].n; j++) begin
                send_frame(pick(vt[i], j),
                           (j == vt[i].bad_idx) ? vt[i].bad_kind : 0,
                           (j == vt[i].n - 1) ? vt[i].mode : 0);
            end
            if (vt[i].has_entry) sb.push_back({vt[i].e_ext, vt[i].e_brk, vt[i].e_code});
            chk($sformatf("vec%0d_frame_err_count", i), err_seen - e0, vt[i].e_err);
            if (vt[i].has_entry) read_check($sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_drained", i), {31'd0, valid}, 32'd0);
        end

        // Nine frames into an 8-deep FIFO without reads: the ninth is dropped.
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 0, 0);
            if (k <= DEP) sb.push_back({2'b00, 8'(k)});
        end
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        for (int k = 1; k <= DEP; k++) read_check($sformatf("ovf_rd%0d", k));
        @(negedge clk);
        chk("ovf_drained", {31'd0, valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        do_reset();
        chk("ovf_cleared_by_rst", {31'd0, overflow}, 32'd0);

        // Full FIFO with a read in the push cycle: accepted, no overflow.
        for (int k = 0; k < DEP; k++) begin
            send_frame(8'h11 + 8'(k), 0, 0);
            sb.push_back({2'b00, 8'h11 + 8'(k)});
        end
        send_frame(8'h19, 0, 2);
        sb.push_back({2'b00, 8'h19});
        chk("rdpush_no_ovf", {31'd0, overflow}, 32'd0);
        for (int k = 0; k < DEP; k++) read_check($sformatf("rdpush_rd%0d", k));
        @(negedge clk);
        chk("rdpush_drained", {31'd0, valid}, 32'd0);

        // Partial frame then a silent bus: timeout abort.
        e0 = err_seen;
        ps2_bit(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0, 1'b0);
        repeat (TO + 20) @(negedge clk);
        chk("timeout_frame_err", err_seen - e0, 32'd1);
        chk("timeout_no_entry", {31'd0, valid}, 32'd0);
        send_frame(8'h29, 0, 0);
        sb.push_back({2'b00, 8'h29});
        read_check("after_timeout");

        // Reset in the middle of a frame with a buffered entry and a pending prefix.
        send_frame(8'h66, 0, 0);
        send_frame(8'hE0, 0, 0);
        ps2_bit(1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("midrst");
        rst = 1'b0;
        sb.delete();
        repeat (5) @(negedge clk);
        chk("midrst_fifo_lost", {31'd0, valid}, 32'd0);
        send_frame(8'h45, 0, 0);
        sb.push_back({2'b00, 8'h45});
        read_check("after_rst");
        @(negedge clk);
        chk("final_drained", {31'd0, valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
